memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/mem_pkg.sv | 32 +++
 rtl/mem_resp_pipe.sv | 42 ++++
 rtl/memory_responder.sv | 99 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : bus encodings, widths and response record shared by the
//           memory responder and its return pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int TAG_W  = 4;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
  } resp_t;

  // Tag 0 means "no tag", so the counter skips it on wrap.
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
    return (tag == '1) ? TAG_W'(1) : tag + TAG_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_pipe.sv
// ============================================================================
// mem_resp_pipe : DEPTH-stage valid/tag/data delay line with synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  resp_t in_i,
  output resp_t out_o
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    resp_t stage_d;
    resp_t stage_q;

    if (i == 0) begin : g_head
      // Empty slots carry all-zero tag and data so the output needs no gating.
      assign stage_d = in_i.valid ? in_i : '0;
    end else begin : g_body
      assign stage_d = g_stage[i-1].stage_q;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  assign out_o = g_stage[DEPTH-1].stage_q;

endmodule

`default_nettype wire

// File: rtl/memory_responder.sv
// ============================================================================
// memory_responder : tagged load/store responder with fixed-latency returns.
//                    Define MEMORY_RESPONDER_ALIGN_CHECK_EN to reject unaligned requests.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_responder
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY     = 4,
  parameter int MEM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [63:0]       MEM_address,
  input  logic [WORD_W-1:0] MEM_value,
  input  logic [1:0]        MEM_command,
  output logic [TAG_W-1:0]  mem_response,
  output logic [WORD_W-1:0] mem_data_out,
  output logic [TAG_W-1:0]  mem_tag_out
);

  localparam int               c_idx_w   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [60:0]      c_words   = 61'(MEM_WORDS);
  localparam logic [TAG_W-1:0] c_max_out = TAG_W'(MAX_OUTSTANDING);

  logic [WORD_W-1:0] mem_q [MEM_WORDS];

  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] outstanding_q, outstanding_d;

  logic [60:0]        word_idx;
  logic [c_idx_w-1:0] mem_idx;
  logic               is_load, is_store, in_range, aligned;
  logic               accept, load_acc;
  resp_t              pipe_in, pipe_out;

  assign word_idx = MEM_address[63:3];
  assign mem_idx  = word_idx[c_idx_w-1:0];
  assign is_load  = (MEM_command == BUS_LOAD);
  assign is_store = (MEM_command == BUS_STORE);
  assign in_range = (word_idx < c_words);

`ifdef MEMORY_RESPONDER_ALIGN_CHECK_EN
  assign aligned = (MEM_address[2:0] == 3'b000);
`else
  logic unused_byte_offset;
  assign unused_byte_offset = ^MEM_address[2:0];
  assign aligned            = 1'b1;
`endif

  // The in-flight limit uses the registered count; a same-cycle return does not free a slot.
  assign accept   = !reset && in_range && aligned &&
                    (is_store || (is_load && (outstanding_q < c_max_out)));
  assign load_acc = accept && is_load;

  assign mem_response = accept ? tag_q : '0;

  assign tag_d         = accept ? next_tag(tag_q) : tag_q;
  assign outstanding_d = outstanding_q + TAG_W'(load_acc) - TAG_W'(pipe_out.valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q         <= TAG_W'(1);
      outstanding_q <= '0;
    end else begin
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Backing store keeps its contents through reset.
  always_ff @(posedge clock) begin
    if (accept && is_store) begin
      mem_q[mem_idx] <= MEM_value;
    end
  end

  assign pipe_in.valid = load_acc;
  assign pipe_in.tag   = tag_q;
  assign pipe_in.data  = mem_q[mem_idx];

  mem_resp_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_resp_pipe (
    .clock (clock),
    .reset (reset),
    .in_i  (pipe_in),
    .out_o (pipe_out)
  );

  assign mem_tag_out  = pipe_out.tag;
  assign mem_data_out = pipe_out.data;

endmodule

`default_nettype wire
